// File: rtl/muldiv_seq.sv
// Iterative 32-step multiply/divide unit for the MIPS Execute stage.
// Owns HI/LO, runs shift-add or restoring divide on operand magnitudes, then fixes signs.
module muldiv_seq #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StartE,
    input  logic [1:0]  MdOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        MfhiE,
    input  logic        MfloE,
    input  logic        MthiE,
    input  logic        MtloE,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        BusyMD,
    output logic        StallMD
);

    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   opb_q, opb_d;    // multiplicand (mul) or divisor (div) magnitude
    logic [31:0]   acc_q, acc_d;    // product high half or partial remainder
    logic [31:0]   wrk_q, wrk_d;    // multiplier shifting out, or dividend/quotient
    logic          is_div_q, is_div_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
    logic          dz_q, dz_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          sign_a, sign_b;
    logic [31:0]   mag_a, mag_b;
    logic [32:0]   sum;
    logic [32:0]   rem_sh;
    logic [33:0]   diff;
    logic [63:0]   prod;

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        wrk_d    = wrk_q;
        is_div_d = is_div_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        sign_a = ~MdOpE[0] & SrcAE[31];
        sign_b = ~MdOpE[0] & SrcBE[31];
        mag_a  = neg32(SrcAE, sign_a);
        mag_b  = neg32(SrcBE, sign_b);

        sum    = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : 33'd0);
        rem_sh = {acc_q, wrk_q[31]};
        diff   = {1'b0, rem_sh} - {2'b00, opb_q};
        prod   = neg64({acc_q, wrk_q}, negq_q);

        case (state_q)
            IDLE: begin
                if (StartE) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = MdOpE[1];
                    negq_d   = sign_a ^ sign_b;
                    negr_d   = sign_a;
                    dz_d     = MdOpE[1] & (SrcBE == 32'd0);
                    acc_d    = 32'd0;
                    opb_d    = MdOpE[1] ? mag_b : mag_a;
                    wrk_d    = MdOpE[1] ? mag_a : mag_b;
                end else begin
                    if (MthiE) hi_d = SrcAE;
                    if (MtloE) lo_d = SrcAE;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    acc_d = diff[33] ? rem_sh[31:0] : diff[31:0];
                    wrk_d = {wrk_q[30:0], ~diff[33]};
                end else begin
                    acc_d = sum[32:1];
                    wrk_d = {sum[0], wrk_q[31:1]};
                end
                if (cnt_q == CW'(ITERS - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (is_div_q) begin
                    // Remainder after a zero divisor is |dividend|; negr restores the original.
                    hi_d = neg32(acc_q, negr_q);
                    lo_d = dz_q ? 32'hFFFF_FFFF : neg32(wrk_q, negq_q);
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opb_q    <= 32'd0;
            acc_q    <= 32'd0;
            wrk_q    <= 32'd0;
            is_div_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            wrk_q    <= wrk_d;
            is_div_q <= is_div_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign HiOut   = hi_q;
    assign LoOut   = lo_q;
    assign BusyMD  = (state_q != IDLE);
    assign StallMD = BusyMD & (StartE | MfhiE | MfloE | MthiE | MtloE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of MULT/DIV vectors plus stall, reset-abort and MTHI/MTLO sequences.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        StartE;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE, SrcBE;
    logic        MfhiE, MfloE, MthiE, MtloE;
    logic [31:0] HiOut, LoOut;
    logic        BusyMD, StallMD;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    muldiv_seq #(.ITERS(32)) dut (
        .clk(clk), .reset(reset), .StartE(StartE), .MdOpE(MdOpE),
        .SrcAE(SrcAE), .SrcBE(SrcBE),
        .MfhiE(MfhiE), .MfloE(MfloE), .MthiE(MthiE), .MtloE(MtloE),
        .HiOut(HiOut), .LoOut(LoOut), .BusyMD(BusyMD), .StallMD(StallMD)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Start an op, count busy cycles after the accepting edge, then check HI/LO.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        @(posedge clk); #1;
        StartE = 1'b1; MdOpE = op; SrcAE = a; SrcBE = b;
        @(posedge clk); #1;
        StartE = 1'b0;
        n = 0;
        while (BusyMD && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk({nm, "_latency"}, n, 33);
        chk({nm, "_hi"}, HiOut, ehi);
        chk({nm, "_lo"}, LoOut, elo);
    endtask

    initial begin
        int n;
        logic seen;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[6] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[9] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};

        reset = 1'b1; StartE = 1'b0; MdOpE = 2'b00; SrcAE = '0; SrcBE = '0;
        MfhiE = 1'b0; MfloE = 1'b0; MthiE = 1'b0; MtloE = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, with MFHI presented
        MfhiE = 1'b1;
        @(negedge clk);
        chk("rst_hi", HiOut, 32'd0);
        chk("rst_lo", LoOut, 32'd0);
        chk("rst_busy", {31'd0, BusyMD}, 32'd0);
        chk("rst_stall", {31'd0, StallMD}, 32'd0);
        @(posedge clk); #1 MfhiE = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // MULT at k, dependent MFLO from k+1: stall exactly 33 cycles
        @(posedge clk); #1;
        StartE = 1'b1; MdOpE = OP_MULT; SrcAE = 32'd6; SrcBE = 32'hFFFF_FFF9;
        @(posedge clk); #1;
        StartE = 1'b0; MfloE = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (StallMD) begin
                n++;
                @(posedge clk); #1;
            end else begin
                seen = 1'b1;
            end
        end
        chk("mflo_stall_cycles", n, 33);
        chk("mflo_lo", LoOut, 32'hFFFF_FFD6);
        chk("mflo_hi", HiOut, 32'hFFFF_FFFF);
        @(posedge clk); #1 MfloE = 1'b0;

        // MULT followed by non-HI/LO instructions: never stalls
        @(posedge clk); #1;
        StartE = 1'b1; MdOpE = OP_MULTU; SrcAE = 32'd3; SrcBE = 32'd4;
        @(posedge clk); #1;
        StartE = 1'b0;
        seen = 1'b0;
        n = 0;
        while (BusyMD && n < 100) begin
            @(negedge clk);
            if (StallMD) seen = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        chk("add_no_stall", {31'd0, seen}, 32'd0);
        chk("add_busy_cycles", n, 33);
        chk("add_lo", LoOut, 32'd12);

        // Reset at step 10 of a DIV aborts without writing HI/LO
        @(posedge clk); #1;
        StartE = 1'b1; MdOpE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7;
        @(posedge clk); #1;
        StartE = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort_busy", {31'd0, BusyMD}, 32'd0);
        chk("abort_hi", HiOut, 32'd0);
        chk("abort_lo", LoOut, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_lo_later", LoOut, 32'd0);

        // MTHI / MTLO in IDLE
        MthiE = 1'b1; SrcAE = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        MthiE = 1'b0;
        chk("mthi_hi", HiOut, 32'hA5A5_A5A5);
        chk("mthi_lo_untouched", LoOut, 32'd0);
        MtloE = 1'b1; SrcAE = 32'h5A5A_0F0F;
        @(posedge clk); #1;
        MtloE = 1'b0;
        chk("mtlo_lo", LoOut, 32'h5A5A_0F0F);
        chk("mtlo_hi_untouched", HiOut, 32'hA5A5_A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
